// File: rtl/rgmii_rx_decode_pkg.sv
// Shared ethernet receive definitions: link speed encodings and the
// nibble-assembly FSM state type used by the RGMII receive decoder.
package rgmii_rx_decode_pkg;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    // LO: the next nibble is a low nibble; HI: a low nibble is held, awaiting its high half.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10
    } rx_state_t;

endpackage

// File: rtl/rgmii_rx_decode.sv
// RGMII receive decoder: turns IDDR rising/falling samples into GMII bytes
// (1000 mode) or assembles nibble pairs (10/100 mode), and captures in-band status.
module rgmii_rx_decode
    import rgmii_rx_decode_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] q1,
    input  logic [4:0] q2,
    input  logic [1:0] speed,
    output logic [7:0] gmii_rxd,
    output logic       gmii_rx_dv,
    output logic       gmii_rx_er,
    output logic       gmii_strobe,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       full_duplex,
    output logic       nibble_err
);

    rx_state_t  state;
    logic [1:0] speed_q;
    logic [3:0] lo_nib;
    logic       lo_er;
    logic       dv;
    logic       er;
    logic       gig;

    assign dv  = q1[4];
    assign er  = q1[4] ^ q2[4];
    // Bit 1 set covers both 1000 and the reserved 2'b11 encoding.
    assign gig = speed_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            speed_q     <= SPEED_1000;
            lo_nib      <= 4'h0;
            lo_er       <= 1'b0;
            gmii_rxd    <= 8'h00;
            gmii_rx_dv  <= 1'b0;
            gmii_rx_er  <= 1'b0;
            gmii_strobe <= 1'b0;
            nibble_err  <= 1'b0;
            link_up     <= 1'b0;
            link_speed  <= 2'b00;
            full_duplex <= 1'b0;
        end else begin
            gmii_strobe <= 1'b0;
            nibble_err  <= 1'b0;

            // Speed is only re-sampled between frames so a frame never changes mode.
            if (state == ST_IDLE && !dv) begin
                speed_q <= speed;
            end

            if (!dv && !er) begin
                link_up     <= q1[0];
                link_speed  <= q1[2:1];
                full_duplex <= q1[3];
            end

            if (gig) begin
                gmii_strobe <= 1'b1;
                gmii_rxd    <= {q2[3:0], q1[3:0]};
                gmii_rx_dv  <= dv;
                gmii_rx_er  <= er;
                state       <= dv ? ST_LO : ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE, ST_LO: begin
                        if (dv) begin
                            lo_nib <= q1[3:0];
                            lo_er  <= er;
                            state  <= ST_HI;
                        end else begin
                            state  <= ST_IDLE;
                        end
                    end
                    ST_HI: begin
                        gmii_strobe <= 1'b1;
                        gmii_rx_dv  <= 1'b1;
                        if (dv) begin
                            gmii_rxd   <= {q1[3:0], lo_nib};
                            gmii_rx_er <= lo_er | er;
                            state      <= ST_LO;
                        end else begin
                            // Frame ended with only a low nibble: flush it flagged as an error.
                            gmii_rxd   <= {4'h0, lo_nib};
                            gmii_rx_er <= 1'b1;
                            nibble_err <= 1'b1;
                            state      <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rgmii_rx_decode.sv
// Directed bench for rgmii_rx_decode: 1000/100/10 decoding, odd-nibble frames,
// in-band status, mid-frame reset and speed change between frames.
module tb_rgmii_rx_decode;

    logic       clk;
    logic       rst_n;
    logic [4:0] q1;
    logic [4:0] q2;
    logic [1:0] speed;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic       gmii_strobe;
    logic       link_up;
    logic [1:0] link_speed;
    logic       full_duplex;
    logic       nibble_err;

    int tests = 0;
    int fails = 0;

    // {strobe, dv, er, nibble_err, rxd}; status {link_up, link_speed, full_duplex}
    logic [11:0] obs;
    logic [3:0]  st;
    assign obs = {gmii_strobe, gmii_rx_dv, gmii_rx_er, nibble_err, gmii_rxd};
    assign st  = {link_up, link_speed, full_duplex};

    localparam logic [11:0] FULL = 12'hFFF;
    localparam logic [11:0] NS   = 12'h900;

    rgmii_rx_decode dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .q1          (q1),
        .q2          (q2),
        .speed       (speed),
        .gmii_rxd    (gmii_rxd),
        .gmii_rx_dv  (gmii_rx_dv),
        .gmii_rx_er  (gmii_rx_er),
        .gmii_strobe (gmii_strobe),
        .link_up     (link_up),
        .link_speed  (link_speed),
        .full_duplex (full_duplex),
        .nibble_err  (nibble_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        q1 = a;
        q2 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        q1    = 5'h00;
        q2    = 5'h00;
        speed = 2'b10;
        #12;
        tests++;
        if ({obs, st} !== 16'h0000) begin
            fails++;
            $display("FAIL reset: got %h expected 0000", {obs, st});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_gig();
        logic [7:0] bytes [8];
        bytes = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5};
        speed = 2'b10;
        cyc(5'h00, 5'h00);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            q1 = {1'b1, bytes[i][3:0]};
            q2 = {1'b1, bytes[i][7:4]};
            #1;
            if (i > 0) begin
                tests++;
                if (obs !== {4'hC, bytes[i-1]}) begin
                    fails++;
                    $display("FAIL gig_latency[%0d]: got %h expected %h", i, obs, {4'hC, bytes[i-1]});
                end
            end
            @(posedge clk);
            #1;
            tests++;
            if (obs !== {4'hC, bytes[i]}) begin
                fails++;
                $display("FAIL gig_byte[%0d]: got %h expected %h", i, obs, {4'hC, bytes[i]});
            end
        end
        cyc(5'h0F, 5'h1F);
        tests++;
        if (obs !== 12'hAFF) begin
            fails++;
            $display("FAIL gig_carrier_ext: got %h expected AFF", obs);
        end
        cyc(5'h00, 5'h00);
        tests++;
        if (obs !== 12'h800) begin
            fails++;
            $display("FAIL gig_idle: got %h expected 800", obs);
        end
    endtask

    task automatic test_status();
        logic [4:0] a [4];
        logic [4:0] b [4];
        logic [3:0] e [4];
        a = '{5'h0D, 5'h02, 5'h12, 5'h06};
        b = '{5'h00, 5'h1A, 5'h12, 5'h00};
        e = '{4'hD, 4'hD, 4'hD, 4'h6};
        speed = 2'b10;
        for (int i = 0; i < 4; i++) begin
            cyc(a[i], b[i]);
            tests++;
            if (st !== e[i]) begin
                fails++;
                $display("FAIL status[%0d]: got %h expected %h", i, st, e[i]);
            end
        end
    endtask

    task automatic test_fast();
        logic [4:0]  a [9];
        logic [4:0]  b [9];
        logic [11:0] e [9];
        logic [11:0] m [9];
        a = '{5'h15, 5'h15, 5'h1D, 5'h15, 5'h00, 5'h00, 5'h17, 5'h18, 5'h00};
        b = '{5'h1A, 5'h1A, 5'h1A, 5'h1A, 5'h00, 5'h00, 5'h00, 5'h10, 5'h00};
        e = '{12'h000, 12'hC55, 12'h000, 12'hC5D, 12'h000, 12'h000, 12'h000, 12'hE87, 12'h000};
        m = '{NS, FULL, NS, FULL, NS, NS, NS, FULL, NS};
        speed = 2'b01;
        cyc(5'h00, 5'h00);
        cyc(5'h00, 5'h00);
        for (int i = 0; i < 9; i++) begin
            cyc(a[i], b[i]);
            tests++;
            if ((obs & m[i]) !== e[i]) begin
                fails++;
                $display("FAIL fast[%0d]: got %h expected %h mask %h", i, obs & m[i], e[i], m[i]);
            end
        end
    endtask

    task automatic test_slow_odd();
        logic [4:0]  a [5];
        logic [11:0] e [5];
        logic [11:0] m [5];
        a = '{5'h11, 5'h12, 5'h13, 5'h00, 5'h00};
        e = '{12'h000, 12'hC21, 12'h000, 12'hF03, 12'h000};
        m = '{NS, FULL, NS, FULL, NS};
        speed = 2'b00;
        cyc(5'h00, 5'h00);
        cyc(5'h00, 5'h00);
        for (int i = 0; i < 5; i++) begin
            cyc(a[i], {a[i][4], 4'h9});
            tests++;
            if ((obs & m[i]) !== e[i]) begin
                fails++;
                $display("FAIL slow_odd[%0d]: got %h expected %h mask %h", i, obs & m[i], e[i], m[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        speed = 2'b01;
        cyc(5'h0D, 5'h00);
        cyc(5'h0D, 5'h00);
        cyc(5'h14, 5'h10);
        cyc(5'h16, 5'h10);
        tests++;
        if (obs !== 12'hC64) begin
            fails++;
            $display("FAIL rst_pre_byte: got %h expected C64", obs);
        end
        cyc(5'h19, 5'h10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({obs, st} !== 16'h0000) begin
            fails++;
            $display("FAIL rst_mid_frame: got %h expected 0000", {obs, st});
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q1 = 5'h00;
        q2 = 5'h00;
        cyc(5'h00, 5'h00);
        cyc(5'h1A, 5'h10);
        tests++;
        if ((obs & NS) !== 12'h000) begin
            fails++;
            $display("FAIL rst_first_nibble: got %h expected 000", obs & NS);
        end
        cyc(5'h1B, 5'h10);
        tests++;
        if (obs !== 12'hCBA) begin
            fails++;
            $display("FAIL rst_new_frame: got %h expected CBA", obs);
        end
        cyc(5'h00, 5'h00);
    endtask

    task automatic test_speed_change();
        logic [4:0]  a [8];
        logic [4:0]  b [8];
        logic [11:0] e [8];
        logic [11:0] m [8];
        a = '{5'h12, 5'h14, 5'h16, 5'h00, 5'h00, 5'h17, 5'h18, 5'h00};
        b = '{5'h11, 5'h13, 5'h15, 5'h00, 5'h00, 5'h10, 5'h10, 5'h00};
        e = '{12'hC12, 12'hC34, 12'hC56, 12'h800, 12'h800, 12'h000, 12'hC87, 12'h000};
        m = '{FULL, FULL, FULL, FULL, FULL, NS, FULL, NS};
        speed = 2'b10;
        cyc(5'h00, 5'h00);
        cyc(5'h00, 5'h00);
        for (int i = 0; i < 8; i++) begin
            cyc(a[i], b[i]);
            if (i == 0) speed = 2'b01;
            tests++;
            if ((obs & m[i]) !== e[i]) begin
                fails++;
                $display("FAIL speed_change[%0d]: got %h expected %h mask %h", i, obs & m[i], e[i], m[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_gig();
        test_status();
        test_fast();
        test_slow_odd();
        test_reset_mid_frame();
        test_speed_change();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rgmii_rx_decode.md
RGMII_RX_DECODE -- requirements
Module: rgmii_rx_decode

Interface
REQ-001 Parameter: none; all behaviour is fixed by the speed input.
REQ-002 clk  input  1  RGMII RX clock, the same clock that drives the upstream input DDR stage.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 q1  input  5  rising-edge sample from the IDDR: [3:0]=RXD[3:0], [4]=RX_CTL.
REQ-005 q2  input  5  falling-edge sample from the IDDR: [3:0]=RXD[7:4], [4]=RX_CTL.
REQ-006 speed  input  2  link speed: 2'b10=1000, 2'b01=100, 2'b00=10, 2'b11 treated as 1000.
REQ-007 gmii_rxd  output  8  assembled receive byte.
REQ-008 gmii_rx_dv  output  1  data-valid flag for the byte on gmii_rxd.
REQ-009 gmii_rx_er  output  1  error flag for the byte on gmii_rxd.
REQ-010 gmii_strobe  output  1  one-cycle pulse; gmii_rxd, gmii_rx_dv and gmii_rx_er are meaningful only when it is high.
REQ-011 link_up  output  1  in-band status: link state.
REQ-012 link_speed  output  2  in-band status: PHY-reported speed.
REQ-013 full_duplex  output  1  in-band status: PHY-reported duplex.
REQ-014 nibble_err  output  1  one-cycle pulse when a frame ends on an odd nibble.

Function
REQ-015 dv SHALL equal q1[4]; er SHALL equal q1[4] XOR q2[4].
REQ-016 In 1000 mode, every cycle SHALL produce gmii_strobe=1 with gmii_rxd={q2[3:0],q1[3:0]}, gmii_rx_dv=dv and gmii_rx_er=er, registered with a latency of 1 clk.
REQ-017 In 10/100 mode, the block SHALL use q1[3:0] only and ignore q2[3:0]; each byte SHALL be assembled from two consecutive cycles, low nibble first.
REQ-018 The 10/100 assembly FSM SHALL have the states IDLE, LO and HI.
REQ-019 IDLE->HI: when dv=1, latch q1[3:0] as the low nibble.
REQ-020 HI->LO: when dv=1, emit {q1[3:0], low nibble}; gmii_strobe=1 on the next cycle; gmii_rx_dv=1; gmii_rx_er = er of either cycle ORed.
REQ-021 LO->HI: when dv=1, latch the next low nibble.
REQ-022 HI with dv=0: emit {4'h0, low nibble} with gmii_rx_dv=1 and gmii_rx_er=1, pulse nibble_err, then go to IDLE.
REQ-023 LO with dv=0: go to IDLE with no strobe.
REQ-024 In IDLE with dv=0, the FSM SHALL emit no strobe and SHALL perform in-band status capture.
REQ-025 A change of speed while dv=1 SHALL take effect only after the FSM returns to IDLE; speed is sampled into a register at IDLE.
REQ-026 In-band status SHALL be captured only when dv=0 and er=0, in any mode: link_up=q1[0], link_speed=q1[2:1], full_duplex=q1[3].
REQ-027 In-band status SHALL hold its value otherwise, including when dv=0 and er=1 (carrier extend / false carrier).
REQ-028 In 1000 mode, cycles with dv=0 SHALL still strobe, so that carrier-extend and false-carrier codes pass through with gmii_rx_dv=0 and gmii_rx_er=1.
REQ-029 In 10/100 mode, cycles with dv=0 SHALL produce no strobe.
REQ-030 All outputs SHALL be driven directly from flops; there SHALL be no combinational path from an input to an output.

Reset
REQ-031 On rst_n=0, asynchronously: gmii_rxd=8'h00, gmii_rx_dv=0, gmii_rx_er=0, gmii_strobe=0, nibble_err=0, link_up=0, link_speed=2'b00, full_duplex=0, FSM=IDLE, latched speed=1000.
REQ-032 Reset deassertion mid-frame SHALL resume in IDLE; the remainder of that frame is treated as a new frame start at the next dv=1.

Structure
REQ-033 The shared ethernet package SHALL hold the speed encodings (SPEED_10, SPEED_100, SPEED_1000) and the FSM state typedef.
REQ-034 The design SHALL be a single module with no sub-modules; the IDDR instance remains outside it, in the PHY wrapper.

Verification
REQ-035 1000 mode: drive q1/q2 for 8 bytes 55,55,55,55,55,55,55,D5 with dv=1 -> 8 consecutive strobes, same bytes, dv=1, er=0, 1-cycle latency.
REQ-036 100 mode: drive nibbles 5,5,D,5 with dv=1, then dv=0 -> bytes 55, 5D, then no further strobe, nibble_err=0.
REQ-037 10 mode, odd length: drive nibbles 1,2,3 then dv=0 -> bytes 21, then 03 with er=1, nibble_err pulse.
REQ-038 Idle with q1[3:0]=4'hD (binary 1101), dv=0, er=0 -> link_up=1, link_speed=2'b10, full_duplex=1; then q1[4]=0, q2[4]=1 (er=1) with other data -> status unchanged.
REQ-039 Assert rst_n=0 in HI state mid-frame in 100 mode -> all outputs reset immediately; after release, the next dv frame assembles correctly from its first nibble.
REQ-040 Toggle speed from 1000 to 100 during a frame -> the frame completes in 1000 mode; the next frame decodes in 100 mode.
